// File: rtl/conv2d_window_sequencer.sv
// Walks FILTER_HEIGHT x FILTER_WIDTH windows over a circular line buffer and releases consumed lines.
// Reads issue combinationally (o_rd_en = RUN & i_ready) and stall with address/sof/eof held while i_ready is low.
module conv2d_window_sequencer #(
    parameter int IN_WIDTH      = 227,
    parameter int IN_HEIGHT     = 227,
    parameter int FILTER_WIDTH  = 11,
    parameter int FILTER_HEIGHT = 11,
    parameter int STRIDE        = 4,
    parameter int BUF_LINES     = 15,
    parameter int ADDR_WIDTH    = 12
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_line_written,
    input  logic                  i_ready,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic                  o_sof,
    output logic                  o_eof,
    output logic                  o_line_release,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow
);

    localparam int OUT_W = (IN_WIDTH - FILTER_WIDTH) / STRIDE + 1;
    localparam int OUT_H = (IN_HEIGHT - FILTER_HEIGHT) / STRIDE + 1;
    localparam int HW    = $clog2(BUF_LINES + 1);
    localparam int LW    = $clog2(BUF_LINES);
    localparam int FRW   = $clog2(FILTER_HEIGHT + 1);
    localparam int FCW   = $clog2(FILTER_WIDTH + 1);
    localparam int OCW   = $clog2(OUT_W + 1);
    localparam int ORW   = $clog2(OUT_H + 1);
    localparam int CBW   = $clog2(IN_WIDTH + 1);
    localparam int RCW   = $clog2(STRIDE + 1);

    generate
        if (BUF_LINES < FILTER_HEIGHT + STRIDE) begin : g_bad_depth
            $error("BUF_LINES must be at least FILTER_HEIGHT+STRIDE");
        end
        if (longint'(BUF_LINES) * longint'(IN_WIDTH) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_addr
            $error("BUF_LINES*IN_WIDTH does not fit in ADDR_WIDTH");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, WAIT_LINES, RUN, RELEASE, DONE} state_t;

    state_t          state, state_nxt;
    logic [HW-1:0]   held, held_nxt;
    logic [LW-1:0]   base, base_adv, cur_line;
    logic [FRW-1:0]  fr;
    logic [FCW-1:0]  fc;
    logic [OCW-1:0]  oc;
    logic [ORW-1:0]  orow;
    logic [CBW-1:0]  col_base;
    logic [RCW-1:0]  rel_cnt;
    logic            last_fc, last_fr, last_oc, last_row, row_end;
    logic            wr_accept;
    int              base_sum;

    assign last_fc  = (fc == FCW'(FILTER_WIDTH - 1));
    assign last_fr  = (fr == FRW'(FILTER_HEIGHT - 1));
    assign last_oc  = (oc == OCW'(OUT_W - 1));
    assign last_row = (orow == ORW'(OUT_H - 1));
    assign row_end  = last_fc && last_fr && last_oc;

    assign o_rd_en        = (state == RUN) && i_ready;
    assign o_sof          = (state == RUN) && (fr == '0) && (fc == '0);
    assign o_eof          = (state == RUN) && last_fr && last_fc;
    assign o_busy         = (state != IDLE);
    assign o_done         = (state == DONE);
    assign o_line_release = (state == RELEASE) && (held != '0);
    // cur_line tracks (base+fr) mod BUF_LINES incrementally so no divider is needed
    assign o_rd_addr      = ADDR_WIDTH'(int'(cur_line) * IN_WIDTH + int'(col_base) + int'(fc));

    // A write into a full buffer is still accepted if a line is freed in the same cycle
    assign wr_accept = i_line_written && ((held != HW'(BUF_LINES)) || o_line_release);

    always_comb begin
        held_nxt = held;
        if (wr_accept && !o_line_release) begin
            held_nxt = held + 1'b1;
        end else if (!wr_accept && o_line_release) begin
            held_nxt = held - 1'b1;
        end
    end

    always_comb begin
        base_sum = int'(base) + STRIDE;
        base_adv = (base_sum >= BUF_LINES) ? LW'(base_sum - BUF_LINES) : LW'(base_sum);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (i_start) state_nxt = WAIT_LINES;
            WAIT_LINES: if (held >= HW'(FILTER_HEIGHT)) state_nxt = RUN;
            RUN:        if (o_rd_en && row_end) state_nxt = RELEASE;
            RELEASE: begin
                if (last_row) begin
                    // drain everything, including lines arriving while draining
                    if ((held == '0) && !i_line_written) state_nxt = DONE;
                end else if (o_line_release && (rel_cnt == RCW'(STRIDE - 1))) begin
                    state_nxt = WAIT_LINES;
                end
            end
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            held       <= '0;
            o_overflow <= 1'b0;
            base       <= '0;
            cur_line   <= '0;
            fr         <= '0;
            fc         <= '0;
            oc         <= '0;
            orow       <= '0;
            col_base   <= '0;
            rel_cnt    <= '0;
        end else begin
            held <= held_nxt;
            if (i_line_written && !wr_accept) begin
                o_overflow <= 1'b1;
            end

            if (o_rd_en) begin
                if (!last_fc) begin
                    fc <= fc + 1'b1;
                end else begin
                    fc <= '0;
                    if (!last_fr) begin
                        fr       <= fr + 1'b1;
                        cur_line <= (cur_line == LW'(BUF_LINES - 1)) ? '0 : cur_line + 1'b1;
                    end else begin
                        fr       <= '0;
                        cur_line <= base;
                        if (!last_oc) begin
                            oc       <= oc + 1'b1;
                            col_base <= col_base + CBW'(STRIDE);
                        end else begin
                            oc       <= '0;
                            col_base <= '0;
                        end
                    end
                end
            end

            if (state == RELEASE) begin
                if (o_line_release) begin
                    rel_cnt <= rel_cnt + 1'b1;
                end
                if (state_nxt == WAIT_LINES) begin
                    base     <= base_adv;
                    cur_line <= base_adv;
                    rel_cnt  <= '0;
                    orow     <= orow + 1'b1;
                end else if (state_nxt == DONE) begin
                    base     <= '0;
                    cur_line <= '0;
                    rel_cnt  <= '0;
                    orow     <= '0;
                end
            end
        end
    end

endmodule
